// File: rtl/pspin_ctrl_pkg.sv
// Shared constants, response codes and FSM encodings for the PsPIN control register file.
// Latency: n/a (types, constants and a pure byte-merge helper only).
// Backpressure: n/a.
package pspin_ctrl_pkg;

    // Byte offsets of the register map (bits [1:0] of the bus address are ignored)
    localparam int unsigned OFF_FETCH_EN     = 32'h0000;
    localparam int unsigned OFF_AUX_RST      = 32'h0004;
    localparam int unsigned OFF_SCRATCH      = 32'h0008;
    localparam int unsigned OFF_ID           = 32'h0100;
    localparam int unsigned OFF_EOC          = 32'h0104;
    localparam int unsigned OFF_BUSY         = 32'h0108;
    localparam int unsigned OFF_EOC_STICKY   = 32'h010C;
    localparam int unsigned OFF_STDOUT_VALID = 32'h0110;
    localparam int unsigned OFF_UNDERFLOW    = 32'h0114;
    localparam int unsigned OFF_MPQ_BASE     = 32'h0200;
    localparam int unsigned OFF_STDOUT_BASE  = 32'h1000;

    localparam logic [7:0] ID_VERSION = 8'h02;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_RESP} rd_state_t;
    typedef enum logic {W_IDLE, W_RESP} wr_state_t;

    // Replace the bytes of 'old' selected by 'strb' with the matching bytes of 'wd'
    function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = wd[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/pspin_ctrl_regfile_if.sv
// AXI-Lite bus bundle between a host master and the PsPIN control register file.
// Latency: none (wires only).
// Backpressure: carried by the valid/ready pairs of each channel.
interface pspin_ctrl_regfile_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/pspin_ctrl_rd_mux.sv
// Read-side address decode: hit flag, read data and stdout channel select for one address.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is sampled.
module pspin_ctrl_rd_mux
    import pspin_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int NUM_CLUSTERS = 2,
    parameter int NUM_MPQ      = 256,
    parameter int NUM_STDOUT   = 1
) (
    input  logic [ADDR_WIDTH-1:0]      addr,
    input  logic [NUM_CLUSTERS-1:0]    fetch_en,
    input  logic                       aux_rst,
    input  logic [31:0]                scratch,
    input  logic [NUM_CLUSTERS-1:0]    eoc,
    input  logic [NUM_CLUSTERS-1:0]    busy,
    input  logic [NUM_CLUSTERS-1:0]    eoc_sticky,
    input  logic [NUM_STDOUT-1:0]      stdout_valid,
    input  logic [15:0]                underflow,
    input  logic [NUM_MPQ-1:0]         mpq_full,
    input  logic [32*NUM_STDOUT-1:0]   stdout_dout,
    output logic                       hit,
    output logic [31:0]                rdata,
    output logic [NUM_STDOUT-1:0]      pop_onehot
);
    localparam int NUM_MPQ_WORDS = NUM_MPQ / 32;

    // Misses read all-ones; pop_onehot marks the addressed stdout channel whether or not it has data
    always_comb begin
        hit        = 1'b0;
        rdata      = '1;
        pop_onehot = '0;
        case (addr)
            ADDR_WIDTH'(OFF_FETCH_EN):     begin hit = 1'b1; rdata = 32'(fetch_en);     end
            ADDR_WIDTH'(OFF_AUX_RST):      begin hit = 1'b1; rdata = 32'(aux_rst);      end
            ADDR_WIDTH'(OFF_SCRATCH):      begin hit = 1'b1; rdata = scratch;           end
            ADDR_WIDTH'(OFF_ID):           begin
                hit   = 1'b1;
                rdata = {8'(NUM_STDOUT), 8'(NUM_CLUSTERS), 8'(NUM_MPQ_WORDS), ID_VERSION};
            end
            ADDR_WIDTH'(OFF_EOC):          begin hit = 1'b1; rdata = 32'(eoc);          end
            ADDR_WIDTH'(OFF_BUSY):         begin hit = 1'b1; rdata = 32'(busy);         end
            ADDR_WIDTH'(OFF_EOC_STICKY):   begin hit = 1'b1; rdata = 32'(eoc_sticky);   end
            ADDR_WIDTH'(OFF_STDOUT_VALID): begin hit = 1'b1; rdata = 32'(stdout_valid); end
            ADDR_WIDTH'(OFF_UNDERFLOW):    begin hit = 1'b1; rdata = 32'(underflow);    end
            default: ;
        endcase
        for (int k = 0; k < NUM_MPQ_WORDS; k++) begin
            if (addr == ADDR_WIDTH'(OFF_MPQ_BASE + 4 * k)) begin
                hit   = 1'b1;
                rdata = mpq_full[32*k +: 32];
            end
        end
        for (int c = 0; c < NUM_STDOUT; c++) begin
            if (addr == ADDR_WIDTH'(OFF_STDOUT_BASE + 4 * c)) begin
                hit           = 1'b1;
                pop_onehot[c] = 1'b1;
                rdata         = stdout_valid[c] ? stdout_dout[32*c +: 32] : '1;
            end
        end
    end
endmodule

// File: rtl/pspin_ctrl_regfile.sv
// AXI-Lite control/status register file driving PsPIN fetch-enable/reset and popping stdout FIFOs.
// Latency: read data and write response one cycle after the handshake; pops one cycle after AR.
// Backpressure: one read and one write outstanding; rvalid/bvalid hold until rready/bready.
module pspin_ctrl_regfile
    import pspin_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int NUM_CLUSTERS = 2,
    parameter int NUM_MPQ      = 256,
    parameter int NUM_STDOUT   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    pspin_ctrl_regfile_if.slave      s_axil,
    output logic [NUM_CLUSTERS-1:0]  cl_fetch_en_o,
    output logic                     aux_rst_o,
    input  logic [NUM_CLUSTERS-1:0]  cl_eoc_i,
    input  logic [NUM_CLUSTERS-1:0]  cl_busy_i,
    input  logic [NUM_MPQ-1:0]       mpq_full_i,
    output logic [NUM_STDOUT-1:0]    stdout_rd_en,
    input  logic [32*NUM_STDOUT-1:0] stdout_dout,
    input  logic [NUM_STDOUT-1:0]    stdout_data_valid
);
    rd_state_t                 rd_state;
    wr_state_t                 wr_state;
    logic                      arready_q, rvalid_q, bvalid_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic [1:0]                rresp_q, bresp_q;
    logic [31:0]               scratch;
    logic [NUM_CLUSTERS-1:0]   eoc_q, eoc_sticky, clr_mask;
    logic [15:0]               underflow;

    logic [ADDR_WIDTH-1:0]     rd_addr, wr_addr;
    logic [STRB_WIDTH-1:0]     wstrb;
    logic                      mux_hit;
    logic [DATA_WIDTH-1:0]     mux_rdata, fetch_new, aux_new, scratch_new, clr_new;
    logic [NUM_STDOUT-1:0]     mux_sel;
    logic                      rd_hs, wr_hs, uf_event;
    logic                      m_fetch, m_aux, m_scratch, m_sticky, m_uf, wr_ok;

    assign rd_addr = {s_axil.araddr[ADDR_WIDTH-1:2], 2'b00};
    assign wr_addr = {s_axil.awaddr[ADDR_WIDTH-1:2], 2'b00};
    assign wstrb   = s_axil.wstrb;

    pspin_ctrl_rd_mux #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NUM_CLUSTERS(NUM_CLUSTERS),
        .NUM_MPQ     (NUM_MPQ),
        .NUM_STDOUT  (NUM_STDOUT)
    ) u_rd_mux (
        .addr        (rd_addr),
        .fetch_en    (cl_fetch_en_o),
        .aux_rst     (aux_rst_o),
        .scratch     (scratch),
        .eoc         (cl_eoc_i),
        .busy        (cl_busy_i),
        .eoc_sticky  (eoc_sticky),
        .stdout_valid(stdout_data_valid),
        .underflow   (underflow),
        .mpq_full    (mpq_full_i),
        .stdout_dout (stdout_dout),
        .hit         (mux_hit),
        .rdata       (mux_rdata),
        .pop_onehot  (mux_sel)
    );

    // AW and W are only ever taken together, and never while reset is asserted
    assign rd_hs    = s_axil.arvalid && arready_q;
    assign wr_hs    = (wr_state == W_IDLE) && s_axil.awvalid && s_axil.wvalid && !rst;
    assign uf_event = rd_hs && (|mux_sel) && !(|(mux_sel & stdout_data_valid));

    assign m_fetch   = (wr_addr == ADDR_WIDTH'(OFF_FETCH_EN));
    assign m_aux     = (wr_addr == ADDR_WIDTH'(OFF_AUX_RST));
    assign m_scratch = (wr_addr == ADDR_WIDTH'(OFF_SCRATCH));
    assign m_sticky  = (wr_addr == ADDR_WIDTH'(OFF_EOC_STICKY));
    assign m_uf      = (wr_addr == ADDR_WIDTH'(OFF_UNDERFLOW));
    assign wr_ok     = m_fetch | m_aux | m_scratch | m_sticky | m_uf;

    assign fetch_new   = apply_strb(32'(cl_fetch_en_o), s_axil.wdata, wstrb);
    assign aux_new     = apply_strb(32'(aux_rst_o), s_axil.wdata, wstrb);
    assign scratch_new = apply_strb(scratch, s_axil.wdata, wstrb);
    assign clr_new     = apply_strb('0, s_axil.wdata, wstrb);
    assign clr_mask    = (wr_hs && m_sticky) ? clr_new[NUM_CLUSTERS-1:0] : '0;

    assign s_axil.arready = arready_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rdata   = rdata_q;
    assign s_axil.rresp   = rresp_q;
    assign s_axil.awready = wr_hs;
    assign s_axil.wready  = wr_hs;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;

    logic unused_ok;
    assign unused_ok = ^{s_axil.awprot, s_axil.arprot, s_axil.araddr[1:0], s_axil.awaddr[1:0],
                         fetch_new, aux_new, clr_new};

    // Read FSM: capture decoded data on AR, hold it until rready, emit the pop strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state     <= R_IDLE;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            stdout_rd_en <= '0;
        end else begin
            stdout_rd_en <= '0;
            case (rd_state)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (rd_hs) begin
                        rd_state     <= R_RESP;
                        arready_q    <= 1'b0;
                        rvalid_q     <= 1'b1;
                        rdata_q      <= mux_rdata;
                        rresp_q      <= mux_hit ? RESP_OKAY : RESP_SLVERR;
                        stdout_rd_en <= mux_sel & stdout_data_valid;
                    end
                end
                R_RESP: begin
                    if (s_axil.rready) begin
                        rd_state  <= R_IDLE;
                        arready_q <= 1'b1;
                        rvalid_q  <= 1'b0;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // Write FSM: one response per accepted AW+W pair, held until bready
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= W_IDLE;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (wr_hs) begin
                        wr_state <= W_RESP;
                        bvalid_q <= 1'b1;
                        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                W_RESP: begin
                    if (s_axil.bready) begin
                        wr_state <= W_IDLE;
                        bvalid_q <= 1'b0;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Byte-strobed RW control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cl_fetch_en_o <= '0;
            aux_rst_o     <= 1'b1;
            scratch       <= '0;
        end else begin
            if (wr_hs && m_fetch)   cl_fetch_en_o <= fetch_new[NUM_CLUSTERS-1:0];
            if (wr_hs && m_aux)     aux_rst_o     <= aux_new[0];
            if (wr_hs && m_scratch) scratch       <= scratch_new;
        end
    end

    // Sticky EOC capture: a rising edge in the same cycle as a W1C clear keeps the bit set
    always_ff @(posedge clk) begin
        if (rst) begin
            eoc_q      <= '0;
            eoc_sticky <= '0;
        end else begin
            eoc_q      <= cl_eoc_i;
            eoc_sticky <= (eoc_sticky & ~clr_mask) | (cl_eoc_i & ~eoc_q);
        end
    end

    // Saturating count of reads from empty stdout channels; a write clears, a coincident read counts
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow <= '0;
        end else if (wr_hs && m_uf) begin
            underflow <= uf_event ? 16'd1 : 16'd0;
        end else if (uf_event && (underflow != 16'hFFFF)) begin
            underflow <= underflow + 16'd1;
        end
    end
endmodule
